// File: rtl/patch_message_tx_if.sv
// Signal bundle between patch_message_tx, the colour sensor stage and the UART transmitter.
// The slave modport is the patch_message_tx side; the master modport is the environment side.
`timescale 1ns/1ps

interface patch_message_tx_if;
  logic [2:0] color;
  logic       valid;
  logic       measure;
  logic [4:0] node_id;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] patch_count;
  logic       msg_done;
  logic       overflow;

  modport master (
    output color, valid, node_id, tx_busy,
    input  measure, tx_data, tx_start, patch_count, msg_done, overflow
  );

  modport slave (
    input  color, valid, node_id, tx_busy,
    output measure, tx_data, tx_start, patch_count, msg_done, overflow
  );
endinterface

// File: rtl/patch_message_tx.sv
// Confirms colour patches from the sensor stage and emits one 9-byte ASCII message
// ("PD-nn-C-#") per new patch to the UART, with a one-entry pending buffer in between.
`timescale 1ns/1ps

module patch_message_tx #(
  parameter int unsigned CONFIRM       = 3,
  parameter int unsigned WHITE_CONFIRM = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  patch_message_tx_if.slave    bus
);

  typedef enum logic [1:0] {S_REQ, S_ACK, S_LOW} sense_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_GAP, T_WAIT} tx_state_t;

  localparam logic [3:0] CONFIRM_RUN = 4'(CONFIRM);
  localparam logic [3:0] WHITE_RUN   = 4'(WHITE_CONFIRM);
  localparam logic [3:0] LAST_IDX    = 4'd8;

  sense_state_t s_state, s_next;
  tx_state_t    t_state, t_next;

  logic       capture;
  logic [1:0] code;
  logic [1:0] last;
  logic [3:0] run, run_next;
  logic       armed;
  logic       patch_event;

  logic       pend_full;
  logic [1:0] pend_color;
  logic [4:0] pend_node;
  logic       load;

  logic [1:0] msg_color;
  logic [4:0] msg_node;
  logic [3:0] idx;
  logic [4:0] tens, ones;
  logic [7:0] letter;
  logic [7:0] cur_byte;

  // ---------------- sensor handshake ----------------
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) s_state <= S_REQ;
    else        s_state <= s_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    s_next      = s_state;
    bus.measure = 1'b0;
    case (s_state)
      S_REQ:   if (bus.valid) s_next = S_ACK;
      S_ACK: begin
        bus.measure = 1'b1;
        s_next      = S_LOW;
      end
      S_LOW:   if (!bus.valid) s_next = S_REQ;
      default: s_next = S_REQ;
    endcase
  end

  // Codes 100..111 collapse onto white before any comparison.
  assign capture = (s_state == S_REQ) && bus.valid;
  assign code    = bus.color[2] ? 2'd0 : bus.color[1:0];

  always_comb begin
    if (code == last) run_next = (run == 4'd15) ? 4'd15 : run + 4'd1;
    else              run_next = 4'd1;
  end

  assign patch_event = capture && (code != 2'd0) && armed && (run_next == CONFIRM_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed <= 1'b1;
      last  <= 2'd0;
      run   <= 4'd0;
    end else if (capture) begin
      last <= code;
      run  <= run_next;
      if (patch_event)                                 armed <= 1'b0;
      else if ((code == 2'd0) && (run_next == WHITE_RUN)) armed <= 1'b1;
    end
  end

  // ---------------- pending slot and counters ----------------
  // A slot being emptied by the TX side this cycle can take a new event in the same cycle.
  assign load = (t_state == T_IDLE) && pend_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_full       <= 1'b0;
      pend_color      <= 2'd0;
      pend_node       <= 5'd0;
      bus.patch_count <= 8'd0;
      bus.overflow    <= 1'b0;
    end else if (patch_event) begin
      if (!pend_full || load) begin
        pend_full       <= 1'b1;
        pend_color      <= code;
        pend_node       <= bus.node_id;
        bus.patch_count <= bus.patch_count + 8'd1;
      end else begin
        bus.overflow <= 1'b1;
      end
    end else if (load) begin
      pend_full <= 1'b0;
    end
  end

  // ---------------- message transmitter ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) t_state <= T_IDLE;
    else        t_state <= t_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      msg_color <= 2'd0;
      msg_node  <= 5'd0;
      idx       <= 4'd0;
    end else if (load) begin
      msg_color <= pend_color;
      msg_node  <= pend_node;
      idx       <= 4'd0;
    end else if ((t_state == T_WAIT) && !bus.tx_busy && (idx != LAST_IDX)) begin
      idx <= idx + 4'd1;
    end
  end

  // Node is at most 31, so the constant divide reduces to a tiny comparator chain.
  assign tens = msg_node / 5'd10;
  assign ones = msg_node % 5'd10;

  always_comb begin
    case (msg_color)
      2'd1:    letter = 8'h52;
      2'd2:    letter = 8'h47;
      2'd3:    letter = 8'h42;
      default: letter = 8'h3F;
    endcase
  end

  always_comb begin
    case (idx)
      4'd0:    cur_byte = 8'h50;
      4'd1:    cur_byte = 8'h44;
      4'd2:    cur_byte = 8'h2D;
      4'd3:    cur_byte = 8'h30 + {3'b000, tens};
      4'd4:    cur_byte = 8'h30 + {3'b000, ones};
      4'd5:    cur_byte = 8'h2D;
      4'd6:    cur_byte = letter;
      4'd7:    cur_byte = 8'h2D;
      4'd8:    cur_byte = 8'h23;
      default: cur_byte = 8'h00;
    endcase
  end

  // T_GAP covers the cycle before the UART raises tx_busy for the byte just launched.
  always_comb begin
    t_next       = t_state;
    bus.tx_start = 1'b0;
    bus.tx_data  = 8'h00;
    bus.msg_done = 1'b0;
    case (t_state)
      T_IDLE: if (pend_full) t_next = T_SEND;
      T_SEND: begin
        bus.tx_data = cur_byte;
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          t_next       = T_GAP;
        end
      end
      T_GAP:  t_next = T_WAIT;
      T_WAIT: begin
        if (!bus.tx_busy) begin
          if (idx == LAST_IDX) begin
            bus.msg_done = 1'b1;
            t_next       = T_IDLE;
          end else begin
            t_next = T_SEND;
          end
        end
      end
      default: t_next = T_IDLE;
    endcase
  end

endmodule

// File: tb/tb_patch_message_tx.sv
// Scoreboard bench for patch_message_tx: directed sensor readings push hand-computed
// message bytes into a queue; a monitor pops and compares on every tx_start.
`timescale 1ns/1ps

module tb_patch_message_tx;

  localparam int BUSY = 3;
  localparam logic [2:0] W = 3'b000, R = 3'b001, G = 3'b010, B = 3'b011;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  patch_message_tx_if bus();

  patch_message_tx #(.CONFIRM(3), .WHITE_CONFIRM(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int         start_cyc_q[$];
  int         cyc = 0;
  int         bytes_sent = 0;
  int         done_count = 0;
  int         meas_count = 0;
  int         last_ack_cyc = 0;

  logic uart_busy = 1'b0;
  logic stall     = 1'b0;
  assign bus.tx_busy = uart_busy | stall;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts strobes and scores every launched byte against the queue.
  initial forever begin
    @(negedge clk);
    if (bus.measure)  meas_count++;
    if (bus.msg_done) done_count++;
    if (bus.tx_start) begin
      bytes_sent++;
      start_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_start actual=%02h required=no_byte (t=%0t)", bus.tx_data, $time);
      end else begin
        check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // UART model: busy from the cycle after tx_start for BUSY cycles.
  initial forever begin
    @(negedge clk);
    if (bus.tx_start) begin
      @(posedge clk);
      #1 uart_busy = 1'b1;
      repeat (BUSY) @(posedge clk);
      #1 uart_busy = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic push_msg(input logic [71:0] m);
    for (int i = 8; i >= 0; i--) exp_q.push_back(m[i*8 +: 8]);
  endtask

  task automatic send_reading(input logic [2:0] c);
    int n;
    @(posedge clk);
    #1 bus.color = c;
    bus.valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.measure && n < 20);
    check("measure_seen", 32'(bus.measure), 32'd1);
    last_ack_cyc = cyc;
    @(posedge clk);
    #1 bus.valid = 1'b0;
  endtask

  task automatic burst(input logic [2:0] c, input int n);
    for (int i = 0; i < n; i++) send_reading(c);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.tx_busy) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (30) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int ack, b0, d0, m0, n;
    bus.color   = W;
    bus.valid   = 1'b0;
    bus.node_id = 5'd7;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_measure",     32'(bus.measure),     32'd0);
    check("rst_tx_start",    32'(bus.tx_start),    32'd0);
    check("rst_tx_data",     32'(bus.tx_data),     32'd0);
    check("rst_patch_count", 32'(bus.patch_count), 32'd0);
    check("rst_msg_done",    32'(bus.msg_done),    32'd0);
    check("rst_overflow",    32'(bus.overflow),    32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Confirmed red, node 7; 100 is a white alias
    send_reading(W);
    send_reading(3'b100);
    send_reading(R);
    send_reading(R);
    push_msg(72'h50_44_2D_30_37_2D_52_2D_23);
    start_cyc_q.delete();
    send_reading(R);
    ack = last_ack_cyc;
    drain("msg1_drain");
    check("msg1_latency", 32'((start_cyc_q.size() > 0) ? start_cyc_q[0] - ack : 0), 32'd1);
    check("msg1_bytes",   32'(start_cyc_q.size()), 32'd9);
    check("msg1_count",   32'(bus.patch_count),    32'd1);
    check("msg1_done",    32'(done_count),         32'd1);

    // Repeat suppression: R x6 total, then single white does not re-arm
    burst(R, 3);
    drain("rep_drain");
    check("rep_count", 32'(bus.patch_count), 32'd1);
    send_reading(W);
    burst(R, 3);
    drain("onewhite_drain");
    check("onewhite_count", 32'(bus.patch_count), 32'd1);
    check("onewhite_done",  32'(done_count),      32'd1);

    // Re-arm with white aliases, blue at node 23
    bus.node_id = 5'd23;
    send_reading(3'b111);
    send_reading(3'b110);
    burst(B, 2);
    push_msg(72'h50_44_2D_32_33_2D_42_2D_23);
    send_reading(B);
    drain("blue_drain");
    check("blue_count", 32'(bus.patch_count), 32'd2);
    check("blue_done",  32'(done_count),      32'd2);

    // Flicker never reaches the confirm run
    burst(W, 2);
    send_reading(R); send_reading(G); send_reading(R);
    send_reading(G); send_reading(B); send_reading(B);
    drain("flicker_drain");
    check("flicker_count", 32'(bus.patch_count), 32'd2);
    check("flicker_done",  32'(done_count),      32'd2);

    // Overflow: UART stalled across three events
    pulse_reset();
    check("ovf_rst_count", 32'(bus.patch_count), 32'd0);
    @(posedge clk);
    #1 stall = 1'b1;
    b0 = bytes_sent;
    d0 = done_count;
    bus.node_id = 5'd31;
    burst(W, 2);
    push_msg(72'h50_44_2D_33_31_2D_52_2D_23);
    burst(R, 3);
    bus.node_id = 5'd9;
    burst(W, 2);
    push_msg(72'h50_44_2D_30_39_2D_47_2D_23);
    burst(G, 3);
    bus.node_id = 5'd4;
    burst(W, 2);
    burst(B, 3);
    repeat (5) @(posedge clk);
    check("ovf_flag",          32'(bus.overflow),     32'd1);
    check("ovf_count",         32'(bus.patch_count),  32'd2);
    check("ovf_stalled_bytes", 32'(bytes_sent - b0),  32'd0);
    #1 stall = 1'b0;
    drain("ovf_drain");
    check("ovf_bytes_after", 32'(bytes_sent - b0), 32'd18);
    check("ovf_done_after",  32'(done_count - d0), 32'd2);
    check("ovf_sticky",      32'(bus.overflow),    32'd1);

    // Handshake: valid held high yields one acknowledge
    m0 = meas_count;
    @(posedge clk);
    #1 bus.color = W;
    bus.valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 bus.valid = 1'b0;
    repeat (2) @(posedge clk);
    check("hs_one_measure", 32'(meas_count - m0), 32'd1);
    send_reading(W);
    check("hs_second_measure", 32'(meas_count - m0), 32'd2);

    // Reset mid-message after byte 4
    bus.node_id = 5'd12;
    b0 = bytes_sent;
    d0 = done_count;
    push_msg(72'h50_44_2D_31_32_2D_52_2D_23);
    burst(R, 3);
    n = 0;
    while ((bytes_sent - b0) < 4 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("abort_bytes_before", 32'(bytes_sent - b0), 32'd4);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("abort_measure",     32'(bus.measure),     32'd0);
    check("abort_tx_start",    32'(bus.tx_start),    32'd0);
    check("abort_tx_data",     32'(bus.tx_data),     32'd0);
    check("abort_patch_count", 32'(bus.patch_count), 32'd0);
    check("abort_msg_done",    32'(bus.msg_done),    32'd0);
    check("abort_overflow",    32'(bus.overflow),    32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    check("abort_no_more_bytes", 32'(bytes_sent - b0), 32'd4);
    check("abort_no_done",       32'(done_count - d0), 32'd0);

    burst(W, 2);
    burst(G, 2);
    push_msg(72'h50_44_2D_31_32_2D_47_2D_23);
    send_reading(G);
    drain("post_abort_drain");
    check("post_abort_count", 32'(bus.patch_count),  32'd1);
    check("post_abort_done",  32'(done_count - d0),  32'd1);
    check("post_abort_bytes", 32'(bytes_sent - b0),  32'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
